// File: rtl/dice_roller_if.sv
// Handshake bundle between the LFSR stage, the dice roller and the pin mapping.
interface dice_roller_if #(
   parameter int LFSR_W = 16,
   parameter int SUM_W  = 9
);
   logic [LFSR_W-1:0] lfsr_bits;
   logic [2:0]        die_sel;
   logic [1:0]        n_dice;
   logic              roll;
   logic              busy;
   logic              result_valid;
   logic [SUM_W-1:0]  result;
   logic [6:0]        last_face;

   modport master (
      output lfsr_bits,
      output die_sel,
      output n_dice,
      output roll,
      input  busy,
      input  result_valid,
      input  result,
      input  last_face
   );

   modport slave (
      input  lfsr_bits,
      input  die_sel,
      input  n_dice,
      input  roll,
      output busy,
      output result_valid,
      output result,
      output last_face
   );
endinterface

// File: rtl/dice_roller.sv
// Unbiased N-dice roller: mask-and-reject sampling of the LFSR word,
// with a bounded-retry fallback mapping so every die finishes.
module dice_roller #(
   parameter int LFSR_W    = 16,
   parameter int SUM_W     = 9,
   parameter int RETRY_MAX = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   dice_roller_if.slave   bus
);

   localparam int RW = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [2:0]       r_sel;
   logic [1:0]       r_nd;
   logic [1:0]       r_cnt;
   logic [RW-1:0]    r_retry;
   logic [SUM_W-1:0] r_sum;
   logic [SUM_W-1:0] r_result;
   logic [6:0]       r_face;
   logic             r_busy;
   logic             r_valid;

   logic [6:0]       w_n;
   logic [6:0]       w_mask;
   logic [6:0]       w_cand;
   logic             w_ok;
   logic             w_force;
   logic [6:0]       w_face;
   logic [SUM_W-1:0] w_sum_nx;
   logic             w_unused;

   // Mask is the smallest all-ones value >= N-1, so mask < 2N always.
   always_comb begin
      w_n    = 7'd4;
      w_mask = 7'd3;
      unique case (r_sel)
         3'd0: begin w_n = 7'd4;   w_mask = 7'd3;   end
         3'd1: begin w_n = 7'd6;   w_mask = 7'd7;   end
         3'd2: begin w_n = 7'd8;   w_mask = 7'd7;   end
         3'd3: begin w_n = 7'd10;  w_mask = 7'd15;  end
         3'd4: begin w_n = 7'd12;  w_mask = 7'd15;  end
         3'd5: begin w_n = 7'd20;  w_mask = 7'd31;  end
         3'd6: begin w_n = 7'd100; w_mask = 7'd127; end
         3'd7: begin w_n = 7'd2;   w_mask = 7'd1;   end
         default: begin w_n = 7'd4; w_mask = 7'd3; end
      endcase
   end

   assign w_cand   = bus.lfsr_bits[6:0] & w_mask;
   assign w_ok     = (w_cand < w_n);
   assign w_force  = (r_retry == RW'(RETRY_MAX - 1));
   assign w_face   = w_ok ? (w_cand + 7'd1)
                          : (w_cand - w_n + 7'd1);
   assign w_sum_nx = r_sum + SUM_W'(w_face);
   assign w_unused = ^bus.lfsr_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_sel    <= 3'd0;
         r_nd     <= 2'd0;
         r_cnt    <= 2'd0;
         r_retry  <= '0;
         r_sum    <= '0;
         r_result <= '0;
         r_face   <= 7'd0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.roll) begin
                  r_sel   <= bus.die_sel;
                  r_nd    <= bus.n_dice;
                  r_sum   <= '0;
                  r_cnt   <= 2'd0;
                  r_retry <= '0;
                  r_busy  <= 1'b1;
                  r_state <= DRAW;
               end
            end
            DRAW: begin
               if (w_ok || w_force) begin
                  r_sum   <= w_sum_nx;
                  r_face  <= w_face;
                  r_retry <= '0;
                  r_cnt   <= r_cnt + 2'd1;
                  if (r_cnt == r_nd) begin
                     r_result <= w_sum_nx;
                     r_valid  <= 1'b1;
                     r_state  <= DONE;
                  end
               end else begin
                  r_retry <= r_retry + 1'b1;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy         = r_busy;
   assign bus.result_valid = r_valid;
   assign bus.result       = r_result;
   assign bus.last_face    = r_face;

endmodule

// File: tb/tb_dice_roller.sv
// Table-driven scoreboard bench for dice_roller (RETRY_MAX=4).
module tb_dice_roller;

   logic clk;
   logic rst_n;

   dice_roller_if #(.LFSR_W(16), .SUM_W(9)) bus ();

   dice_roller #(
      .LFSR_W(16),
      .SUM_W(9),
      .RETRY_MAX(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]      sel;
      logic [1:0]      nd;
      logic [3:0][6:0] seq;
      logic [8:0]      res;
      logic [6:0]      face;
      int              lat;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] q[$];
   vec_t        vecs[9];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] sel, input logic [1:0] nd,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input int res, input int face, input int lat);
      vec_t v;
      v.sel  = sel;
      v.nd   = nd;
      v.seq  = {s3, s2, s1, s0};
      v.res  = 9'(res);
      v.face = 7'(face);
      v.lat  = lat;
      return v;
   endfunction

   task automatic drive_lfsr(input logic [6:0] lo);
      logic [8:0] hi;
      hi = 9'($urandom);
      bus.lfsr_bits = {hi, lo};
   endtask

   // Scoreboard: every result_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.result_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got result %0d want none", bus.result);
         end else begin
            logic [15:0] e;
            e = q.pop_front();
            chk("result", int'(bus.result), int'(e[15:7]));
            chk("last_face", int'(bus.last_face), int'(e[6:0]));
         end
      end
   end

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      bit got;
      @(negedge clk);
      bus.die_sel = v.sel;
      bus.n_dice  = v.nd;
      bus.roll    = 1'b1;
      drive_lfsr(v.seq[0]);
      q.push_back({v.res, v.face});
      lat = 0;
      got = 1'b0;
      for (int i = 1; i <= 60 && !got; i++) begin
         @(negedge clk);
         bus.roll = 1'b0;
         drive_lfsr(v.seq[(i - 1) > 3 ? 3 : (i - 1)]);
         if (bus.result_valid) begin
            lat = i;
            got = 1'b1;
         end
      end
      chk($sformatf("latency[%0d]", idx), lat, v.lat);
      @(negedge clk);
      chk($sformatf("valid_low[%0d]", idx), int'(bus.result_valid), 0);
      chk($sformatf("busy_low[%0d]", idx), int'(bus.busy), 0);
   endtask

   initial begin
      int cnt;
      int p1;
      int p2;

      vecs[0] = mk(3'd1, 2'd0, 7'd3,   7'd3,   7'd3,   7'd3,   4,   4,   2);
      vecs[1] = mk(3'd5, 2'd0, 7'd25,  7'd25,  7'd19,  7'd19,  20,  20,  4);
      vecs[2] = mk(3'd6, 2'd0, 7'd127, 7'd127, 7'd127, 7'd127, 28,  28,  5);
      vecs[3] = mk(3'd2, 2'd3, 7'd7,   7'd7,   7'd7,   7'd7,   32,  8,   5);
      vecs[4] = mk(3'd7, 2'd3, 7'd0,   7'd1,   7'd2,   7'd3,   6,   2,   5);
      vecs[5] = mk(3'd0, 2'd3, 7'd0,   7'd1,   7'd2,   7'd3,   10,  4,   5);
      vecs[6] = mk(3'd4, 2'd1, 7'd15,  7'd15,  7'd15,  7'd15,  8,   4,   9);
      vecs[7] = mk(3'd3, 2'd2, 7'd9,   7'd0,   7'd5,   7'd5,   17,  6,   4);
      vecs[8] = mk(3'd6, 2'd3, 7'd99,  7'd99,  7'd99,  7'd99,  400, 100, 5);

      rst_n         = 1'b0;
      bus.roll      = 1'b0;
      bus.die_sel   = 3'd0;
      bus.n_dice    = 2'd0;
      bus.lfsr_bits = 16'h0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_valid", int'(bus.result_valid), 0);
      chk("rst_result", int'(bus.result), 0);
      chk("rst_face", int'(bus.last_face), 0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Roll held high: re-triggers only after IDLE, one-cycle gap.
      @(negedge clk);
      bus.die_sel = 3'd1;
      bus.n_dice  = 2'd0;
      bus.roll    = 1'b1;
      drive_lfsr(7'd3);
      q.push_back({9'd4, 7'd4});
      q.push_back({9'd4, 7'd4});
      cnt = 0; p1 = 0; p2 = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         drive_lfsr(7'd3);
         if (i == 4) bus.roll = 1'b0;
         if (bus.result_valid) begin
            cnt++;
            if (cnt == 1) p1 = i;
            if (cnt == 2) p2 = i;
         end
      end
      chk("held_count", cnt, 2);
      chk("held_pos1", p1, 2);
      chk("held_pos2", p2, 5);

      // Roll and input changes mid-roll are ignored.
      @(negedge clk);
      bus.die_sel = 3'd2;
      bus.n_dice  = 2'd3;
      bus.roll    = 1'b1;
      drive_lfsr(7'd7);
      q.push_back({9'd32, 7'd8});
      cnt = 0; p1 = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         drive_lfsr(7'd7);
         bus.roll = (i == 2);
         if (i == 2) begin
            bus.die_sel = 3'd0;
            bus.n_dice  = 2'd0;
         end
         if (bus.result_valid) begin
            cnt++;
            if (cnt == 1) p1 = i;
         end
      end
      chk("busy_roll_count", cnt, 1);
      chk("busy_roll_pos", p1, 5);

      // Async reset mid-DRAW clears everything, including the old result.
      @(negedge clk);
      bus.die_sel = 3'd2;
      bus.n_dice  = 2'd3;
      bus.roll    = 1'b1;
      drive_lfsr(7'd7);
      @(negedge clk);
      bus.roll = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", int'(bus.busy), 1);
      chk("pre_rst_face", int'(bus.last_face), 8);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_result", int'(bus.result), 0);
      chk("mid_rst_face", int'(bus.last_face), 0);
      chk("mid_rst_valid", int'(bus.result_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.result_valid) cnt++;
      end
      chk("post_rst_no_valid", cnt, 0);
      chk("post_rst_busy", int'(bus.busy), 0);

      run_vec(vecs[0], 100);
      chk("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
